// File: rtl/tap_pkg.sv
// +--------------------------------------------------------------------+
// | tap_pkg : shared state encoding and gate-enable sets for the TAP   |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package tap_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      TLR    = 4'hF,
      RTI    = 4'hC,
      SEL_DR = 4'h7,
      CAP_DR = 4'h6,
      SH_DR  = 4'h2,
      EX1_DR = 4'h1,
      PAU_DR = 4'h3,
      EX2_DR = 4'h0,
      UPD_DR = 4'h5,
      SEL_IR = 4'h4,
      CAP_IR = 4'hE,
      SH_IR  = 4'hA,
      EX1_IR = 4'h9,
      PAU_IR = 4'hB,
      EX2_IR = 4'h8,
      UPD_IR = 4'hD
   } tap_state_t;

   // One bit per encoding: bit n set means state n enables that gated clock.
   localparam logic [15:0] IR_GATE_SET = (16'h1 << CAP_IR) | (16'h1 << SH_IR);
   localparam logic [15:0] DR_GATE_SET = (16'h1 << CAP_DR) | (16'h1 << SH_DR);

   function automatic logic in_set(input tap_state_t s, input logic [15:0] set);
      return set[s];
   endfunction

endpackage

`default_nettype wire

// File: rtl/tap_clk_gate.sv
// +--------------------------------------------------------------------+
// | tap_clk_gate : negedge-latched enable ANDed with tck               |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tap_clk_gate (
   input  logic tck,
   input  logic trst,
   input  logic en,
   output logic gclk
);

   logic en_q;

   // Enable only moves while tck is low, so gclk never gets a partial pulse.
   always_ff @(negedge tck or posedge trst) begin
      if (trst) en_q <= 1'b0;
      else      en_q <= en;
   end

   assign gclk = tck & en_q;

endmodule

`default_nettype wire

// File: rtl/tap_controller.sv
// +--------------------------------------------------------------------+
// | tap_controller : IEEE 1149.1 TAP FSM, strobes, gated clocks, TDO   |
// | Optional: TAP_STATE_OBS_EN adds debug port tap_state[3:0]          |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tap_controller
   import tap_pkg::*;
(
   input  logic tck,
   input  logic trst,
   input  logic tms,
   input  logic tdo_ir,
   input  logic tdo_dr,
   output logic tl_reset,
   output logic captureIR,
   output logic shiftIR,
   output logic updateIR,
   output logic captureDR,
   output logic shiftDR,
   output logic updateDR,
   output logic tck_ir,
   output logic tck_dr,
   output logic tdo,
   output logic tdo_en
`ifdef TAP_STATE_OBS_EN
   ,
   output logic [STATE_W-1:0] tap_state
`endif
);

   tap_state_t state_q, state_d;

   logic tl_reset_q, tl_reset_d;
   logic update_ir_q, update_ir_d;
   logic update_dr_q, update_dr_d;
   logic tdo_q, tdo_d;
   logic tdo_en_q, tdo_en_d;
   logic en_ir_d, en_dr_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:     state_d = tms ? TLR    : RTI;
         RTI:     state_d = tms ? SEL_DR : RTI;
         SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
         CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
         SH_DR:   state_d = tms ? EX1_DR : SH_DR;
         EX1_DR:  state_d = tms ? UPD_DR : PAU_DR;
         PAU_DR:  state_d = tms ? EX2_DR : PAU_DR;
         EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
         UPD_DR:  state_d = tms ? SEL_DR : RTI;
         SEL_IR:  state_d = tms ? TLR    : CAP_IR;
         CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
         SH_IR:   state_d = tms ? EX1_IR : SH_IR;
         EX1_IR:  state_d = tms ? UPD_IR : PAU_IR;
         PAU_IR:  state_d = tms ? EX2_IR : PAU_IR;
         EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
         UPD_IR:  state_d = tms ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   always_ff @(posedge tck or posedge trst) begin
      if (trst) state_q <= TLR;
      else      state_q <= state_d;
   end

   assign captureIR = (state_q == CAP_IR);
   assign shiftIR   = (state_q == SH_IR);
   assign captureDR = (state_q == CAP_DR);
   assign shiftDR   = (state_q == SH_DR);

   // Falling-edge outputs: update strobes rise mid-state, TDO is held between shifts.
   always_comb begin
      tl_reset_d  = (state_q != TLR);
      update_ir_d = (state_q == UPD_IR);
      update_dr_d = (state_q == UPD_DR);
      tdo_en_d    = shiftIR | shiftDR;
      tdo_d       = tdo_q;
      if (shiftIR)      tdo_d = tdo_ir;
      else if (shiftDR) tdo_d = tdo_dr;
   end

   always_ff @(negedge tck or posedge trst) begin
      if (trst) begin
         tl_reset_q  <= 1'b0;
         update_ir_q <= 1'b0;
         update_dr_q <= 1'b0;
         tdo_q       <= 1'b0;
         tdo_en_q    <= 1'b0;
      end else begin
         tl_reset_q  <= tl_reset_d;
         update_ir_q <= update_ir_d;
         update_dr_q <= update_dr_d;
         tdo_q       <= tdo_d;
         tdo_en_q    <= tdo_en_d;
      end
   end

   assign tl_reset = tl_reset_q;
   assign updateIR = update_ir_q;
   assign updateDR = update_dr_q;
   assign tdo      = tdo_q;
   assign tdo_en   = tdo_en_q;

   assign en_ir_d = in_set(state_q, IR_GATE_SET);
   assign en_dr_d = in_set(state_q, DR_GATE_SET);

   tap_clk_gate u_gate_ir (
      .tck  (tck),
      .trst (trst),
      .en   (en_ir_d),
      .gclk (tck_ir)
   );

   tap_clk_gate u_gate_dr (
      .tck  (tck),
      .trst (trst),
      .en   (en_dr_d),
      .gclk (tck_dr)
   );

`ifdef TAP_STATE_OBS_EN
   assign tap_state = state_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tap_controller.sv
// +--------------------------------------------------------------------+
// | tb_tap_controller : directed + random bench against a table model  |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_tap_controller;

   logic tck, trst, tms, tdo_ir, tdo_dr;
   logic tl_reset, captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR;
   logic tck_ir, tck_dr, tdo, tdo_en;
`ifdef TAP_STATE_OBS_EN
   logic [3:0] tap_state;
`endif

   tap_controller dut (
      .tck       (tck),
      .trst      (trst),
      .tms       (tms),
      .tdo_ir    (tdo_ir),
      .tdo_dr    (tdo_dr),
      .tl_reset  (tl_reset),
      .captureIR (captureIR),
      .shiftIR   (shiftIR),
      .updateIR  (updateIR),
      .captureDR (captureDR),
      .shiftDR   (shiftDR),
      .updateDR  (updateDR),
      .tck_ir    (tck_ir),
      .tck_dr    (tck_dr),
      .tdo       (tdo),
      .tdo_en    (tdo_en)
`ifdef TAP_STATE_OBS_EN
      ,
      .tap_state (tap_state)
`endif
   );

   // Model states numbered in the order the standard lists them; each arm is
   // Capture, Shift, Exit1, Pause, Exit2, Update at consecutive indices.
   localparam int M_TLR = 0, M_RTI = 1, M_SDR = 2, M_CDR = 3, M_SHDR = 4, M_UDR = 8;
   localparam int M_SIR = 9, M_CIR = 10, M_SHIR = 11, M_UIR = 15;

   int checks = 0;
   int errors = 0;
   int ir_edges = 0, dr_edges = 0, uir_pulses = 0, udr_pulses = 0;
   int exp_ir_edges = 0, exp_dr_edges = 0;
   int mst;
   logic e_tlrn, e_uir, e_udr, e_tdo, e_tdoen;

   always @(posedge tck_ir)   ir_edges++;
   always @(posedge tck_dr)   dr_edges++;
   always @(posedge updateIR) uir_pulses++;
   always @(posedge updateDR) udr_pulses++;

   function automatic int nxt(input int s, input logic t);
      int base, p;
      if (s == M_TLR) return t ? M_TLR : M_RTI;
      if (s == M_RTI) return t ? M_SDR : M_RTI;
      if (s == M_SDR) return t ? M_SIR : M_CDR;
      if (s == M_SIR) return t ? M_TLR : M_CIR;
      base = (s >= M_CIR) ? M_CIR : M_CDR;
      p    = s - base;
      case (p)
         0, 1:    return t ? base + 2 : base + 1;
         2:       return t ? base + 5 : base + 3;
         3:       return t ? base + 4 : base + 3;
         4:       return t ? base + 5 : base + 1;
         default: return t ? M_SDR : M_RTI;
      endcase
   endfunction

`ifdef TAP_STATE_OBS_EN
   function automatic logic [3:0] enc(input int s);
      logic [3:0] tbl [16];
      tbl = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
              4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
      return tbl[s];
   endfunction
`endif

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [8:0] o, e;
      o = {captureIR, shiftIR, captureDR, shiftDR, tl_reset, updateIR, updateDR, tdo_en, tdo};
      e = {mst == M_CIR, mst == M_SHIR, mst == M_CDR, mst == M_SHDR,
           e_tlrn, e_uir, e_udr, e_tdoen, e_tdo};
      check(tag, {7'd0, o}, {7'd0, e});
      check({tag, "_ir_edges"}, 16'(ir_edges), 16'(exp_ir_edges));
      check({tag, "_dr_edges"}, 16'(dr_edges), 16'(exp_dr_edges));
`ifdef TAP_STATE_OBS_EN
      check({tag, "_state"}, {12'd0, tap_state}, {12'd0, enc(mst)});
`endif
   endtask

   task automatic model_rise(input logic t);
      if (mst == M_CIR || mst == M_SHIR) exp_ir_edges++;
      if (mst == M_CDR || mst == M_SHDR) exp_dr_edges++;
      mst = nxt(mst, t);
   endtask

   task automatic model_fall();
      e_tlrn  = (mst != M_TLR);
      e_uir   = (mst == M_UIR);
      e_udr   = (mst == M_UDR);
      e_tdoen = (mst == M_SHIR) || (mst == M_SHDR);
      if (mst == M_SHIR)      e_tdo = tdo_ir;
      else if (mst == M_SHDR) e_tdo = tdo_dr;
   endtask

   task automatic tick(input logic t, input string tag);
      tms    = t;
      tdo_ir = 1'($urandom);
      tdo_dr = 1'($urandom);
      #4 tck = 1'b1;
      model_rise(t);
      #5 tck = 1'b0;
      model_fall();
      #1 check_all(tag);
   endtask

   task automatic model_reset();
      mst = M_TLR;
      e_tlrn = 1'b0; e_uir = 1'b0; e_udr = 1'b0; e_tdo = 1'b0; e_tdoen = 1'b0;
   endtask

   initial begin
      int snap, snap2, cap_cycles;
      tck = 1'b0; trst = 1'b1; tms = 1'b0; tdo_ir = 1'b0; tdo_dr = 1'b0;
      model_reset();

      // Reset with tck stopped
      #3 check_all("reset");
      check("reset_gclk", {14'd0, tck_ir, tck_dr}, 16'd0);
      trst = 1'b0;
      #3 tick(1'b0, "tlr_to_rti");

      // ShDR then five tms=1 back to TLR
      tick(1'b1, "to_seldr");
      tick(1'b0, "to_capdr");
      tick(1'b0, "to_shdr");
      snap = udr_pulses;
      for (int i = 0; i < 5; i++) tick(1'b1, "five_ones");
      check("five_ones_tlr", {15'd0, tl_reset}, 16'd0);
      check("five_ones_updr_pulse", 16'(udr_pulses - snap), 16'd1);

      // IR load
      tick(1'b0, "ir_rti");
      snap = ir_edges; snap2 = uir_pulses; cap_cycles = 0;
      tick(1'b1, "ir_seldr");
      tick(1'b1, "ir_selir");
      tick(1'b0, "ir_capir");
      cap_cycles += int'(captureIR);
      tick(1'b0, "ir_shir");
      cap_cycles += int'(captureIR);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, "ir_shift");
         cap_cycles += int'(captureIR);
      end
      tick(1'b1, "ir_ex1");
      check("ir_tdo_en_off", {15'd0, tdo_en}, 16'd0);
      tick(1'b1, "ir_upd");
      check("ir_update_high", {15'd0, updateIR}, 16'd1);
      tick(1'b0, "ir_back_rti");
      check("ir_tck_edges", 16'(ir_edges - snap), 16'd5);
      check("ir_update_pulses", 16'(uir_pulses - snap2), 16'd1);
      check("ir_capture_cycles", 16'(cap_cycles), 16'd1);

      // Pause in the DR arm
      tick(1'b1, "p_seldr");
      tick(1'b0, "p_capdr");
      tick(1'b1, "p_ex1dr");
      snap = dr_edges;
      tick(1'b0, "p_pause");
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, "p_hold");
         check("p_no_shift", {15'd0, shiftDR}, 16'd0);
      end
      check("p_no_tck_dr", 16'(dr_edges - snap), 16'd0);
      tick(1'b1, "p_ex2dr");
      tick(1'b0, "p_shdr");
      tick(1'b0, "p_shdr2");
      check("p_tck_dr_resume", 16'(dr_edges - snap), 16'd1);
      for (int i = 0; i < 5; i++) tick(1'b1, "p_exit");

      // Reset while tck is high in Shift-IR
      tick(1'b0, "r_rti");
      tick(1'b1, "r_seldr");
      tick(1'b1, "r_selir");
      tick(1'b0, "r_capir");
      tick(1'b0, "r_shir");
      snap2 = uir_pulses;
      tms = 1'b0;
      #4 tck = 1'b1;
      model_rise(1'b0);
      #2 check("r_gclk_high", {15'd0, tck_ir}, 16'd1);
      trst = 1'b1;
      #1 check("r_gclk_drop", {15'd0, tck_ir}, 16'd0);
      model_reset();
      check_all("r_async");
      #2 tck = 1'b0;
      #1 check_all("r_held");
      trst = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b1, "r_after");
      check("r_no_update_ir", 16'(uir_pulses - snap2), 16'd0);

      // Random walk, with periodic five-ones recovery
      for (int n = 0; n < 400; n++) begin
         if (n % 60 == 59) begin
            for (int i = 0; i < 5; i++) tick(1'b1, "rand_five");
            check("rand_five_tlr", {15'd0, tl_reset}, 16'd0);
         end else begin
            tick(1'($urandom_range(0, 2) == 0), "rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1 TAP state machine. Sits directly upstream of the instruction register and the data registers.
- Decodes TMS on tck into the 16 TAP states.
- Produces capture/shift/update strobes, gated shift clocks tck_ir/tck_dr and the active-low test-logic reset tl_reset.
- Muxes and retimes TDO onto the falling edge of tck.

Parameters:
- STATE_W, 4, width of the state encoding (fixed by the standard encoding below; do not override)

Ports:
- tck  input  1  test clock; only clock in the block
- trst  input  1  asynchronous active-high reset
- tms  input  1  test mode select, sampled on posedge tck
- tdo_ir  input  1  serial out of instruction register
- tdo_dr  input  1  serial out of the selected data register
- tl_reset  output  1  active-low test-logic reset to IR/DR (low while in Test-Logic-Reset)
- captureIR  output  1  high in Capture-IR
- shiftIR  output  1  high in Shift-IR
- updateIR  output  1  update strobe for IR latch
- captureDR  output  1  high in Capture-DR
- shiftDR  output  1  high in Shift-DR
- updateDR  output  1  update strobe for DR latches
- tck_ir  output  1  tck gated to Capture-IR/Shift-IR
- tck_dr  output  1  tck gated to Capture-DR/Shift-DR
- tdo  output  1  retimed serial output
- tdo_en  output  1  output enable for the TDO pad

Behaviour:
- State encoding (hex): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D.
- Transitions on posedge tck per 1149.1, written as tms=0 / tms=1:
  - TLR→RTI/TLR; RTI→RTI/SelDR
  - SelDR→CapDR/SelIR; SelIR→CapIR/TLR
  - Cap→Sh/Ex1; Sh→Sh/Ex1; Ex1→Pau/Upd; Pau→Pau/Ex2; Ex2→Sh/Upd
  - Upd→RTI/SelDR (both IR and DR arms)
- trst=1 (async): state=TLR, tl_reset=0, updateIR=updateDR=0, gate enables=0, tdo=0, tdo_en=0.
- trst deasserted mid-sequence: the next posedge evaluates from TLR.
- captureIR/shiftIR/captureDR/shiftDR are combinational decodes of the current state.
- Registers that shift on posedge of the gated clock sample the strobe for the state being exited.
- Negedge-registered outputs (updated on every falling edge of tck):
  - tl_reset = ~(state==TLR)
  - updateIR = (state==UpdIR); updateDR = (state==UpdDR)
    - Rises half a cycle after entering Update, falls half a cycle after leaving.
    - Rising edge falls mid-state, so the IR latch triggers once per pass through Update.
  - en_ir = state∈{CapIR,ShIR}; en_dr = state∈{CapDR,ShDR}
  - tdo_en = shiftIR|shiftDR
  - tdo = shiftIR ? tdo_ir : tdo_dr, held when not shifting
- Gated clocks:
  - tck_ir = tck & en_ir; tck_dr = tck & en_dr.
  - Enable changes only while tck is low, so no glitches or partial pulses.
  - Exactly one tck_ir rising edge per tck cycle spent in CapIR/ShIR.
- Five consecutive tms=1 from any state reach TLR.
- tms=X is not tolerated; the bench never drives it.

Optional Feature:
- Macro TAP_STATE_OBS_EN.
- Defined: extra output port tap_state [3:0] driven by the current state register (encoding above), for debug/ILA.
- Undefined: port absent; state stays internal. Nothing else changes.

Decomposition:
- Shared package tap_pkg:
  - enum tap_state_t with the 16 encodings above.
  - Localparams for the gate-enable state sets.
- One natural sub-module: tap_clk_gate.
  - Negedge enable flop plus AND.
  - Instantiated twice, for tck_ir and tck_dr.
- FSM and TDO retiming stay in tap_controller.

Test Plan:
- Reset: pulse trst with tck stopped → tl_reset=0, all strobes 0, tdo_en=0. Release trst, tms=0, one posedge → state C, tl_reset=1 after next negedge.
- From ShDR (2), five posedges with tms=1 → state F. tl_reset low at the negedge after the fifth edge; updateDR pulses once in between (passes UpdDR).
- IR load: from RTI, tms 1,1,0,0, then tms=0×3, then 1,1:
  - captureIR high 1 cycle.
  - tck_ir produces 1+4 rising edges (1 capture plus 3 in Shift-IR and 1 on leaving it).
  - updateIR rises at the negedge in UpdIR; exactly one pulse.
- TDO: in ShIR with tdo_ir=1, tdo_dr=0 → tdo=1 and tdo_en=1 after negedge. In Ex1IR → tdo_en=0 after the next negedge.
- Pause: CapDR→Ex1DR→PauDR, hold tms=0 ×4 → no tck_dr edges, shiftDR=0. Then Ex2DR→ShDR (tms 1,0) → tck_dr resumes.
- Reset mid-shift: assert trst while tck high in ShIR → tck_ir drops immediately, state F, updateIR never asserts.
